// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: per-channel FSM state codes
// and the debounce counter width helper.
package sw_debounce_pkg;

  // Per-channel debounce FSM states. The two stable states (S_LO, S_HI)
  // hold the reported level; the two check states count stable cycles of
  // the opposite level before accepting it.
  localparam logic [1:0] S_LO     = 2'd0;
  localparam logic [1:0] S_CHK_HI = 2'd1;
  localparam logic [1:0] S_HI     = 2'd2;
  localparam logic [1:0] S_CHK_LO = 2'd3;

  // Counter width able to hold 0 .. cycles-1; at least one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// Single debounce channel: 2-flop synchronizer, 4-state debounce FSM with
// stable-cycle counter, registered level output and edge pulses.
module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic db_out,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          sync2;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          hi_nxt;

  // Bring the asynchronous switch level into the clk domain; nothing else
  // looks at sw_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // Next-state and counter logic. Any return of the synced level to the
  // current stable value abandons the check and clears the count; the
  // count resets again on acceptance so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_LO: begin
        if (sync2) begin
          state_nxt = S_CHK_HI;
          cnt_nxt   = '0;
        end
      end
      S_CHK_HI: begin
        if (!sync2) begin
          state_nxt = S_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_HI: begin
        if (!sync2) begin
          state_nxt = S_CHK_LO;
          cnt_nxt   = '0;
        end
      end
      S_CHK_LO: begin
        if (sync2) begin
          state_nxt = S_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = S_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The reported level is high in S_HI and S_CHK_LO; computing it from the
  // next state keeps db_out in step with the state register.
  assign hi_nxt = (state_nxt == S_HI) || (state_nxt == S_CHK_LO);

  // State, counter, level and pulse registers. Pulses fire only on the
  // accepting transitions, so rise and fall are mutually exclusive and
  // line up with the first cycle db_out shows the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_LO;
      cnt    <= '0;
      db_out <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      db_out <= hi_nxt;
      rise   <= (state == S_CHK_HI) && (state_nxt == S_HI);
      fall   <= (state == S_CHK_LO) && (state_nxt == S_LO);
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer. Each bit of sw_in gets its own fully
// independent channel; db_out bits drive the mux a/b/sel inputs downstream.
module sw_debounce #(
  parameter int CH        = 3,
  parameter int DB_CYCLES = 500000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sw_in,
  output logic [CH-1:0] db_out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    sw_debounce_ch #(
      .DB_CYCLES (DB_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .sw_in  (sw_in[i]),
      .db_out (db_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter CH, default 3, number of independent switch channels; bit0 feeds mux a, bit1 feeds mux b, bit2 feeds mux sel.
REQ-002 Parameter DB_CYCLES, default 500000 (10 ms at 50 MHz), stable-cycle count required to accept a level change; legal range >= 2.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sw_in  input  CH  raw asynchronous board switch levels.
REQ-006 db_out  output  CH  debounced, clk-synchronous switch levels.
REQ-007 rise  output  CH  one-cycle pulse when db_out[i] goes 0->1.
REQ-008 fall  output  CH  one-cycle pulse when db_out[i] goes 1->0.

Function
REQ-009 Each channel SHALL pass sw_in[i] through a 2-flop synchronizer (sync1, sync2) before any use; no other logic touches sw_in.
REQ-010 Each channel SHALL run its own 4-state FSM: S_LO, S_CHK_HI, S_HI, S_CHK_LO, with a counter of width clog2(DB_CYCLES).
REQ-011 S_LO: sync2=1 -> S_CHK_HI, cnt=0; else stay.
REQ-012 S_CHK_HI: sync2=0 -> S_LO, cnt=0; sync2=1 and cnt=DB_CYCLES-1 -> S_HI; sync2=1 otherwise -> cnt+1.
REQ-013 S_HI and S_CHK_LO SHALL mirror REQ-011/012 with levels inverted.
REQ-014 db_out[i] SHALL be 1 exactly in S_HI and S_CHK_LO, registered (no combinational path from sw_in).
REQ-015 rise[i]/fall[i] SHALL be registered, asserted for exactly the one cycle in which db_out[i] first shows the new level.
REQ-016 Latency: a clean edge on sw_in sampled at clock edge E SHALL appear on db_out at edge E+2+DB_CYCLES.
REQ-017 Any excursion whose sync2 duration is <= DB_CYCLES cycles SHALL be rejected: db_out unchanged, no pulse, FSM returns to its stable state with cnt=0.
REQ-018 Counter SHALL never wrap; it saturates at DB_CYCLES-1 only at the transition cycle.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.
REQ-020 rise and fall of one channel SHALL never be asserted together.

Reset
REQ-021 While rst=1 at a clock edge: sync1=sync2=0, state=S_LO, cnt=0, db_out=0, rise=0, fall=0 for every channel.
REQ-022 Reset asserted mid-debounce SHALL abandon the count with no pulse; a switch held high through reset SHALL be reported as db_out=1 with one rise pulse at edge R+2+DB_CYCLES after the first post-reset edge R.

Structure
REQ-023 Shared package sw_debounce_pkg SHALL hold the FSM state enumeration and the counter-width constant function.
REQ-024 One sub-module sw_debounce_ch (single channel: synchronizer, FSM, counter, pulse regs) SHALL be instantiated CH times by a generate loop; top holds no other logic.
REQ-025 db_out SHALL connect directly to mxu2 a/b/sel; the LED output of mxu2 is unaffected by this block.

Verification (DB_CYCLES=4, CH=3)
REQ-026 Reset 3 cycles with sw_in=3'b111 -> all outputs 0 during reset; db_out=3'b111 and rise=3'b111 for one cycle at the 6th edge after release.
REQ-027 sw_in[0] 0->1 held -> db_out[0]=1 exactly 6 edges after the first sampling edge; rise[0] single pulse; fall never asserted.
REQ-028 sw_in[1] high-glitch of 3 cycles, then bounces 1/0/1/0 each 1 cycle -> db_out[1] stays 0, no pulses.
REQ-029 sw_in[2] high 5 cycles then low -> accepted (rise at edge 6); following low held -> fall pulse 6 edges after the falling edge sample.
REQ-030 rst pulsed during S_CHK_HI at cnt=2 -> no rise, db_out=0, counting restarts from 0 after release.
REQ-031 All 8 sw_in combinations applied at 100-cycle spacing -> db_out follows each with latency 6, and mxu2 out equals sel ? b : a on debounced values.
